alarm_bank: RTL

Multi-channel alarm unit for the digital watch, sitting beside the timekeeping counter and feeding the display/buzzer driver. Holds `N_ALARMS` independent hour:minute alarms with per-channel enable, edited through the three watch buttons. Compares them against the running time at each minute boundary and drives a latched buzzer with auto-timeout. Fully synchronous to the system clock; button inputs are edge-detected internally.

---
 rtl/alarm_pkg.sv | 26 ++
 rtl/alarm_bank_button_edge.sv | 28 ++
 rtl/alarm_bank.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm bank.
// Edit states double as the BlinkAlm field encoding.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIN  = 2'd1,
        ST_HR   = 2'd2,
        ST_EN   = 2'd3
    } edit_st_e;

    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    typedef struct packed {
        logic       en;
        logic [4:0] hr;
        logic [5:0] min;
    } alarm_t;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v,
                                            input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_bank_button_edge.sv
// Button synchroniser plus rising-edge detector.
// One pulse per press regardless of hold time.
module button_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel hour:minute alarm bank with button editor and buzzer.
// Define ALARM_BANK_SNOOZE_EN to build the snooze counter.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter  int N_ALARMS   = 4,
    parameter  int RING_SECS  = 60,
    parameter  int SNOOZE_MIN = 5,
    localparam int CW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                Clk,
    input  logic                RstN,
    input  logic [5:0]          SecTk,
    input  logic [5:0]          MinTk,
    input  logic [4:0]          HrTk,
    input  logic                Button1Alm,
    input  logic                Button2Alm,
    input  logic                Button3Alm,
    output logic [CW-1:0]       EditCh,
    output logic [5:0]          MinAlm,
    output logic [4:0]          HrAlm,
    output logic [1:0]          BlinkAlm,
    output logic [N_ALARMS-1:0] AlarmEn,
    output logic                BuzzerBit,
    output logic [CW-1:0]       RingCh
);

    if (N_ALARMS < 1 || N_ALARMS > 16 || RING_SECS < 1 || RING_SECS > 255 ||
        SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_cfg
        $error("alarm_bank: parameter out of range");
    end

    logic b1, b2, b3;

    button_edge u_b1 (.clk_i(Clk), .rst_ni(RstN), .btn_i(Button1Alm), .pulse_o(b1));
    button_edge u_b2 (.clk_i(Clk), .rst_ni(RstN), .btn_i(Button2Alm), .pulse_o(b2));
    button_edge u_b3 (.clk_i(Clk), .rst_ni(RstN), .btn_i(Button3Alm), .pulse_o(b3));

    alarm_t        alm_q [N_ALARMS];
    edit_st_e      st_q;
    logic [CW-1:0] ch_q;
    logic [5:0]    sec_q;
    logic          ring_q;
    logic [7:0]    ring_cnt_q;
    logic [CW-1:0] ring_ch_q;
    logic          boundary, sec_chg;
    logic          hit;
    logic [CW-1:0] hit_ch;
    logic          ed_b1, ed_b2;

    assign boundary = (SecTk == 6'd0) && (sec_q != 6'd0);
    assign sec_chg  = (SecTk != sec_q);

    // Walk downward so the lowest matching index is the one kept.
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (alm_q[i].en && alm_q[i].min == MinTk && alm_q[i].hr == HrTk) begin
                hit    = 1'b1;
                hit_ch = CW'(i);
            end
        end
        hit = hit && boundary;
    end

`ifdef ALARM_BANK_SNOOZE_EN
    logic [5:0] snz_q;

    assign ed_b1 = b1 & ~ring_q;
    assign ed_b2 = b2 & ~ring_q & (snz_q == 6'd0);
`else
    assign ed_b1 = b1;
    assign ed_b2 = b2;
`endif

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            st_q <= ST_IDLE;
            ch_q <= '0;
            for (int i = 0; i < N_ALARMS; i++) alm_q[i] <= '0;
        end else if (ed_b1) begin
            unique case (st_q)
                ST_IDLE: st_q <= ST_MIN;
                ST_MIN:  st_q <= ST_HR;
                ST_HR:   st_q <= ST_EN;
                ST_EN: begin
                    if (ch_q == CW'(N_ALARMS - 1)) begin
                        st_q <= ST_IDLE;
                        ch_q <= '0;
                    end else begin
                        st_q <= ST_MIN;
                        ch_q <= ch_q + 1'b1;
                    end
                end
            endcase
        end else if (ed_b2) begin
            unique case (st_q)
                ST_IDLE: ;
                ST_MIN:  alm_q[ch_q].min <= inc_wrap(alm_q[ch_q].min, 6'(MIN_MAX));
                ST_HR:   alm_q[ch_q].hr  <= 5'(inc_wrap({1'b0, alm_q[ch_q].hr}, 6'(HR_MAX)));
                ST_EN:   alm_q[ch_q].en  <= ~alm_q[ch_q].en;
            endcase
        end
    end

    // A fresh match always wins over dismiss and timeout.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            sec_q      <= '0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
            ring_ch_q  <= '0;
`ifdef ALARM_BANK_SNOOZE_EN
            snz_q      <= '0;
`endif
        end else begin
            sec_q <= SecTk;
            if (hit) begin
                ring_q     <= 1'b1;
                ring_cnt_q <= 8'(RING_SECS);
                ring_ch_q  <= hit_ch;
`ifdef ALARM_BANK_SNOOZE_EN
                snz_q      <= '0;
`endif
            end else if (ring_q) begin
                if (b3) begin
                    ring_q     <= 1'b0;
                    ring_cnt_q <= '0;
`ifdef ALARM_BANK_SNOOZE_EN
                    snz_q      <= 6'(SNOOZE_MIN);
`endif
                end
`ifdef ALARM_BANK_SNOOZE_EN
                else if (b2) begin
                    ring_q     <= 1'b0;
                    ring_cnt_q <= '0;
                    snz_q      <= '0;
                end
`endif
                else if (sec_chg) begin
                    ring_cnt_q <= ring_cnt_q - 8'd1;
                    if (ring_cnt_q == 8'd1) ring_q <= 1'b0;
                end
            end
`ifdef ALARM_BANK_SNOOZE_EN
            else if (snz_q != 6'd0) begin
                if (b2) begin
                    snz_q <= '0;
                end else if (boundary) begin
                    snz_q <= snz_q - 6'd1;
                    if (snz_q == 6'd1) begin
                        ring_q     <= 1'b1;
                        ring_cnt_q <= 8'(RING_SECS);
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        AlarmEn = '0;
        for (int i = 0; i < N_ALARMS; i++) AlarmEn[i] = alm_q[i].en;
    end

    assign EditCh    = ch_q;
    assign MinAlm    = alm_q[ch_q].min;
    assign HrAlm     = alm_q[ch_q].hr;
    assign BlinkAlm  = st_q;
    assign BuzzerBit = ring_q;
    assign RingCh    = ring_ch_q;

endmodule
